snd_cmd_fifo: RTL

- Command path from the main V33 CPU to the Z80 sound CPU, downstream of the main CPU IO decode (sound latch write at IO 0x00).
- Buffers main-CPU sound command bytes in a small FIFO and presents the oldest byte to the sound CPU.
- Drives a Z80 mode-0 interrupt request with a fixed RST vector; the sound CPU acknowledges it through a dedicated port.
- Reports full/pending status back to the main side, including a sticky overflow flag.

---
 rtl/snd_cmd_fifo.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/snd_cmd_fifo.sv
// ---------------------------------------------------------------------------
// snd_cmd_fifo
//
// Sound command path from the main V33 CPU to the Z80 sound CPU. The main
// CPU's sound-latch writes (IO 0x00) are queued in a small FIFO. The oldest
// byte is presented to the sound CPU on a registered output. A Z80 mode-0
// interrupt request with a fixed RST vector tells the sound CPU that
// commands are waiting.
//
// Ports:
//   clk_sys        system clock
//   reset_n        asynchronous active-low reset
//   snd_reset      synchronous clear (sound CPU reset), same effect as reset
//   main_wr        one-cycle pulse, enqueue main_din
//   main_din[7:0]  command byte from the main CPU
//   main_full      FIFO holds DEPTH entries (combinational)
//   main_overflow  sticky: a write arrived while full and was dropped
//   main_clr_ovf   one-cycle pulse, clears main_overflow (a new overflow wins)
//   snd_rd         one-cycle pulse, pop the head entry
//   snd_dout[7:0]  head byte, registered
//   snd_ack        one-cycle pulse, interrupt acknowledge from the sound CPU
//   snd_irq        interrupt request, level, active high
//   snd_vector     constant IRQ_VECTOR (RST opcode for mode-0 fetch)
//   pending        current fill count
// ---------------------------------------------------------------------------
module snd_cmd_fifo #(
  parameter int         DEPTH      = 4,
  parameter logic [7:0] IRQ_VECTOR = 8'hDF,
  parameter int         HOLDOFF    = 2
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     snd_reset,
  input  logic                     main_wr,
  input  logic [7:0]               main_din,
  output logic                     main_full,
  output logic                     main_overflow,
  input  logic                     main_clr_ovf,
  input  logic                     snd_rd,
  output logic [7:0]               snd_dout,
  input  logic                     snd_ack,
  output logic                     snd_irq,
  output logic [7:0]               snd_vector,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [HW-1:0] HOLDOFF_C = HW'(HOLDOFF);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Storage and state
  // -------------------------------------------------------------------------
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic [7:0]    dout_reg;
  logic          ovf_reg;
  state_t        state_reg;
  state_t        state_next;
  logic [HW-1:0] hold_reg;
  logic [HW-1:0] hold_next;

  logic full_w;
  logic empty_w;
  logic do_wr;
  logic do_rd;
  logic ovf_set;

  // -------------------------------------------------------------------------
  // FIFO control
  // -------------------------------------------------------------------------
  assign full_w  = (count_reg == DEPTH_C);
  assign empty_w = (count_reg == '0);

  // A pop in the same cycle frees the slot, so a write while full still lands.
  assign do_wr   = main_wr && (!full_w || snd_rd);
  // Popping an empty FIFO does nothing; a same-cycle write is then write-only.
  assign do_rd   = snd_rd && !empty_w;
  assign ovf_set = main_wr && full_w && !snd_rd;

  always_comb begin
    count_next = count_reg;
    if (do_wr && !do_rd) begin
      count_next = count_reg + CW'(1);
    end else if (!do_wr && do_rd) begin
      count_next = count_reg - CW'(1);
    end
  end

  // Entry array: no reset so it maps onto distributed/block RAM.
  always_ff @(posedge clk_sys) begin
    if (do_wr && !snd_reset) begin
      mem[wr_ptr_reg] <= main_din;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else if (snd_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      // Pointers are PW bits wide, so the increment wraps modulo DEPTH.
      if (do_wr) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (do_rd) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      count_reg <= count_next;
      // Set has priority over clear so a same-cycle overflow is never lost.
      if (ovf_set) begin
        ovf_reg <= 1'b1;
      end else if (main_clr_ovf) begin
        ovf_reg <= 1'b0;
      end
    end
  end

  // Head register. It only reloads while the FIFO holds data, so once the
  // last byte is popped the output keeps showing it instead of a stale slot.
  // The one-edge lag means a byte written into an empty FIFO shows up one
  // edge after the write, and the next byte one edge after a pop.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dout_reg <= 8'h00;
    end else if (snd_reset) begin
      dout_reg <= 8'h00;
    end else if (!empty_w) begin
      dout_reg <= mem[rd_ptr_reg];
    end
  end

  // -------------------------------------------------------------------------
  // Interrupt FSM
  // -------------------------------------------------------------------------
  // Entry into ASSERT requires data both now and after this edge, so a pop
  // that drains the last byte on the same edge cannot raise a dead interrupt.
  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    case (state_reg)
      ST_IDLE: begin
        if (!empty_w && (count_next != '0)) begin
          state_next = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        // Only the acknowledge drops the request; reads alone do not.
        if (snd_ack) begin
          state_next = ST_HOLD;
          hold_next  = HOLDOFF_C;
        end
      end
      ST_HOLD: begin
        // Low for HOLDOFF+1 cycles: HOLDOFF decrements plus the exit cycle.
        if (hold_reg == '0) begin
          if (!empty_w && (count_next != '0)) begin
            state_next = ST_ASSERT;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          hold_next = hold_reg - HW'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        hold_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      hold_reg  <= '0;
    end else if (snd_reset) begin
      state_reg <= ST_IDLE;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign main_full     = full_w;
  assign main_overflow = ovf_reg;
  assign snd_dout      = dout_reg;
  assign snd_irq       = (state_reg == ST_ASSERT);
  assign snd_vector    = IRQ_VECTOR;
  assign pending       = count_reg;

endmodule
